// File: rtl/host_mem_responder.sv
// Host-memory responder: services line read/write/dump requests from a 512-bit line
// store after programmable latencies, answering on common_data_bus_in.
module host_mem_responder #(
    parameter int DEPTH_BITS    = 10,
    parameter int READ_LATENCY  = 4,
    parameter int WRITE_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            op,
    input  logic [31:0]           io_addr,
    input  logic [511:0]          common_data_bus_out,
    input  logic [63:0]           cv_value,
    input  logic                  pre_we,
    input  logic [DEPTH_BITS-1:0] pre_idx,
    input  logic [511:0]          pre_data,
    output logic [511:0]          common_data_bus_in,
    output logic                  rd_valid,
    output logic                  tx_done,
    output logic                  busy,
    output logic                  dump_seen,
    output logic [63:0]           dump_value,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [2:0] {IDLE, RD_WAIT, WR_WAIT, DUMP, RESP, RECOVER} stateT;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_DUMP  = 2'b11;

    stateT                  state, nextState;
    logic [1:0]             opQ;
    logic [DEPTH_BITS-1:0]  idxQ;
    logic [511:0]           wrDataQ;
    logic [15:0]            latCnt;
    logic                   accept, readFire, writeFire;
    logic [511:0]           mem [0:(1<<DEPTH_BITS)-1];
    logic                   unusedAddrBits;

    assign unusedAddrBits = ^{io_addr[31:6+DEPTH_BITS], io_addr[5:0]};

    always_comb begin
        nextState = state;
        accept    = 1'b0;
        readFire  = 1'b0;
        writeFire = 1'b0;
        rd_valid  = 1'b0;
        tx_done   = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (op != 2'b00) begin
                    accept = 1'b1;
                    if (op == OP_READ)       nextState = RD_WAIT;
                    else if (op == OP_WRITE) nextState = WR_WAIT;
                    else                     nextState = DUMP;
                end
            end
            RD_WAIT: begin
                if (latCnt == '0) begin
                    readFire  = 1'b1;
                    nextState = RESP;
                end
            end
            WR_WAIT: begin
                if (latCnt == '0) begin
                    writeFire = 1'b1;
                    nextState = RESP;
                end
            end
            DUMP:    nextState = RESP;
            RESP: begin
                tx_done   = 1'b1;
                rd_valid  = (opQ == OP_READ);
                nextState = RECOVER;
            end
            RECOVER: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            opQ                <= '0;
            idxQ               <= '0;
            wrDataQ            <= '0;
            latCnt             <= '0;
            common_data_bus_in <= '0;
            dump_seen          <= 1'b0;
            dump_value         <= '0;
            rd_count           <= '0;
            wr_count           <= '0;
        end else begin
            state <= nextState;
            if (accept) begin
                opQ     <= op;
                idxQ    <= io_addr[6 +: DEPTH_BITS];
                wrDataQ <= common_data_bus_out;
                latCnt  <= (op == OP_READ) ? 16'(READ_LATENCY - 1) : 16'(WRITE_LATENCY - 1);
                if (op == OP_DUMP) dump_value <= cv_value;
            end else if ((state == RD_WAIT || state == WR_WAIT) && latCnt != '0) begin
                latCnt <= latCnt - 16'd1;
            end
            if (readFire) begin
                common_data_bus_in <= mem[idxQ];
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
            if (writeFire && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            if (state == DUMP) dump_seen <= 1'b1;
        end
    end

    // Commit is ordered after the preload so it wins a same-index collision; a read
    // sampling in the same cycle sees the pre-edge contents.
    always_ff @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        if (writeFire && !rst) mem[idxQ] <= wrDataQ;
    end

endmodule
